mig_app_responder: RTL and testbench

- Synthesizable stand-in for the DDR3 controller's application (app_*) interface. It is the memory-side responder to our traffic generators and to the sound-sample fetch logic.
- Accepts write and read commands, stores 256-bit words in on-chip RAM, and returns read data after a fixed latency.
- Emulates calibration delay and periodic backpressure, so initiators can be simulated and run on boards without external DDR3.

---
 rtl/mig_app_responder_if.sv | 29 ++
 rtl/mig_app_responder.sv | 151 +++++++++++++++
 tb/tb_mig_app_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_app_responder_if.sv
// Application-side bus of the DDR3 controller stand-in: command, write-data and read-return channels.
interface mig_app_responder_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned MASK_W = 32,
  parameter int unsigned ADDR_W = 29
);
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_app_responder.sv
// On-chip responder for the DDR3 app_* interface: calibration delay, periodic backpressure,
// byte-masked word RAM and a fixed-latency in-order read return path.
module mig_app_responder #(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned MASK_W       = 32,
  parameter int unsigned ADDR_W       = 29,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned CALIB_CYCLES = 1000,
  parameter int unsigned RD_LATENCY   = 8,
  parameter int unsigned STALL_PERIOD = 16
) (
  input  logic                 ui_clk,
  input  logic                 sys_rst,
  mig_app_responder_if.slave   app,
  output logic                 init_calib_complete,
  output logic                 proto_err,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);

  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam int unsigned CAL_W    = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned PH_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int unsigned PH_LAST  = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;
  localparam int unsigned PH_HALF  = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD / 2 - 1;
  localparam bit          STALL_EN = (STALL_PERIOD != 0);

  typedef enum logic {ST_CALIB, ST_RUN} state_t;

  state_t            state, state_nxt;
  logic [CAL_W-1:0]  cal_cnt;
  logic              calib_done, run_nxt;

  logic [PH_W-1:0]   phase, phase_nxt;
  logic              rdy_q, wdf_rdy_q;

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              cmd_hs, wd_hs, is_wr, is_rd, wr_ok, viol, wr_acc, rd_acc;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] dsh [RD_LATENCY-1];
  logic [RD_LATENCY-1:0] vld;
  logic [DATA_W-1:0] rd_data_q;

  // ---------------- calibration FSM ----------------
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= ST_CALIB;
      cal_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CALIB) cal_cnt <= cal_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CALIB: if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CALIB;
    endcase
  end

  always_comb begin
    calib_done = (state == ST_RUN);
    run_nxt    = (state_nxt == ST_RUN);
  end

  assign init_calib_complete = calib_done;

  // ---------------- backpressure phase ----------------
  always_comb begin
    phase_nxt = '0;
    if (calib_done && phase != PH_W'(PH_LAST)) phase_nxt = phase + 1'b1;
  end

  // Ready flags are registered from the next phase so they track the phase register exactly.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      phase     <= '0;
      rdy_q     <= 1'b0;
      wdf_rdy_q <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      rdy_q     <= run_nxt && (!STALL_EN || phase_nxt != PH_W'(PH_LAST));
      wdf_rdy_q <= run_nxt && (!STALL_EN || phase_nxt != PH_W'(PH_HALF));
    end
  end

  // ---------------- command decode and protocol check ----------------
  assign addr = app.app_addr;
  assign idx  = addr[3 +: IDX_W];

  always_comb begin
    cmd_hs = app.app_en && rdy_q;
    wd_hs  = app.app_wdf_wren && wdf_rdy_q;
    is_wr  = (app.app_cmd == 3'd0);
    is_rd  = (app.app_cmd == 3'd1);
    wr_ok  = cmd_hs && is_wr && wd_hs && app.app_wdf_end;
    viol   = (cmd_hs && !is_wr && !is_rd)
          || (cmd_hs && is_wr && !(wd_hs && app.app_wdf_end))
          || (wd_hs && !wr_ok)
          || (app.app_wdf_wren && !app.app_wdf_end)
          || (!calib_done && (app.app_en || app.app_wdf_wren));
    wr_acc = wr_ok && !viol;
    rd_acc = cmd_hs && is_rd && !viol;
  end

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      proto_err <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      if (viol)   proto_err <= 1'b1;
      if (wr_acc) wr_count  <= wr_count + 16'd1;
      if (rd_acc) rd_count  <= rd_count + 16'd1;
    end
  end

  // ---------------- backing RAM and read data shift ----------------
  // Read-before-write port; a write one cycle earlier is already committed, so no bypass is needed.
  always_ff @(posedge ui_clk) begin
    if (wr_acc) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (!app.app_wdf_mask[b]) mem[idx][b*8 +: 8] <= app.app_wdf_data[b*8 +: 8];
      end
    end
    if (rd_acc) dsh[0] <= mem[idx];
    for (int unsigned i = 1; i < RD_LATENCY - 1; i++) dsh[i] <= dsh[i-1];
  end

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vld       <= '0;
      rd_data_q <= '0;
    end else begin
      vld <= {vld[RD_LATENCY-2:0], rd_acc};
      if (vld[RD_LATENCY-2]) rd_data_q <= dsh[RD_LATENCY-2];
    end
  end

  assign app.app_rdy           = rdy_q;
  assign app.app_wdf_rdy       = wdf_rdy_q;
  assign app.app_rd_data       = rd_data_q;
  assign app.app_rd_data_valid = vld[RD_LATENCY-1];
  assign app.app_rd_data_end   = vld[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: two instances, backpressure period 16 (A) and 4 (B).
module tb_mig_app_responder;
  localparam int unsigned DW  = 256;
  localparam int unsigned MW  = 32;
  localparam int unsigned AW  = 29;
  localparam int          LAT = 8;

  logic ui_clk = 1'b0;
  logic sys_rst;
  always #5 ui_clk = ~ui_clk;

  mig_app_responder_if #(.DATA_W(DW), .MASK_W(MW), .ADDR_W(AW)) ifa ();
  mig_app_responder_if #(.DATA_W(DW), .MASK_W(MW), .ADDR_W(AW)) ifb ();

  logic        calib_a, err_a, calib_b, err_b;
  logic [15:0] wc_a, rc_a, wc_b, rc_b;

  mig_app_responder #(.DATA_W(DW), .MASK_W(MW), .ADDR_W(AW), .MEM_DEPTH(256),
                      .CALIB_CYCLES(1000), .RD_LATENCY(LAT), .STALL_PERIOD(16)) u_dut_a (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .app(ifa),
    .init_calib_complete(calib_a), .proto_err(err_a), .wr_count(wc_a), .rd_count(rc_a));

  mig_app_responder #(.DATA_W(DW), .MASK_W(MW), .ADDR_W(AW), .MEM_DEPTH(256),
                      .CALIB_CYCLES(1000), .RD_LATENCY(LAT), .STALL_PERIOD(4)) u_dut_b (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .app(ifb),
    .init_calib_complete(calib_b), .proto_err(err_b), .wr_count(wc_b), .rd_count(rc_b));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int beats_b  = 0;
  logic [DW-1:0] qa_exp[$], qb_exp[$];
  int            qa_acc[$], qb_acc[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic rdy(input bit b);
    return b ? ifb.app_rdy : ifa.app_rdy;
  endfunction

  function automatic logic wdf_rdy(input bit b);
    return b ? ifb.app_wdf_rdy : ifa.app_wdf_rdy;
  endfunction

  task automatic put(input bit b, input logic en, input logic [2:0] cmd, input logic [AW-1:0] addr,
                     input logic wren, input logic wend, input logic [DW-1:0] data, input logic [MW-1:0] mask);
    if (b) begin
      ifb.app_en = en; ifb.app_cmd = cmd; ifb.app_addr = addr;
      ifb.app_wdf_wren = wren; ifb.app_wdf_end = wend; ifb.app_wdf_data = data; ifb.app_wdf_mask = mask;
    end else begin
      ifa.app_en = en; ifa.app_cmd = cmd; ifa.app_addr = addr;
      ifa.app_wdf_wren = wren; ifa.app_wdf_end = wend; ifa.app_wdf_data = data; ifa.app_wdf_mask = mask;
    end
  endtask

  task automatic idle(input bit b);
    put(b, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push_exp(input bit b, input logic [DW-1:0] v);
    if (b) qb_exp.push_back(v);
    else   qa_exp.push_back(v);
  endtask

  task automatic wait_ready(input bit b, input bit need_wdf, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (rdy(b) && (!need_wdf || wdf_rdy(b))) begin
        ok = 1'b1;
        break;
      end
      @(negedge ui_clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic do_write(input bit b, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [MW-1:0] mask);
    bit ok;
    wait_ready(b, 1'b1, ok);
    if (ok) begin
      put(b, 1'b1, 3'd0, addr, 1'b1, 1'b1, data, mask);
      @(negedge ui_clk);
      idle(b);
    end
  endtask

  task automatic do_read(input bit b, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bit ok;
    wait_ready(b, 1'b0, ok);
    if (ok) begin
      push_exp(b, exp);
      put(b, 1'b1, 3'd1, addr, 1'b0, 1'b0, '0, '0);
      @(negedge ui_clk);
      idle(b);
    end
  endtask

  // Hold app_en high; the address advances after each cycle the responder was ready.
  task automatic read_hold(input bit b, input int cycles, input int want, input int s, input int base, output int n);
    n = 0;
    for (int c = 0; c < cycles && n < want; c++) begin
      put(b, 1'b1, 3'd1, AW'((s + n) * 8), 1'b0, 1'b0, '0, '0);
      if (rdy(b)) begin
        push_exp(b, DW'(base + n));
        n++;
      end
      @(negedge ui_clk);
    end
    idle(b);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (qa_exp.size() + qb_exp.size()) != 0; i++) @(negedge ui_clk);
    check("drain_outstanding", qa_exp.size() + qb_exp.size(), 0);
  endtask

  // Acceptance timestamps, judged from the bus itself.
  always @(posedge ui_clk) begin
    if (sys_rst) begin
      if (ifa.app_en && ifa.app_rdy && ifa.app_cmd == 3'd1 && !ifa.app_wdf_wren) qa_acc.push_back(cyc);
      if (ifb.app_en && ifb.app_rdy && ifb.app_cmd == 3'd1 && !ifb.app_wdf_wren) qb_acc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  always @(negedge ui_clk) begin
    logic [DW-1:0] e;
    if (!sys_rst) begin
      qa_exp.delete(); qa_acc.delete(); qb_exp.delete(); qb_acc.delete();
    end else begin
      if (ifa.app_rd_data_valid) begin
        if (qa_exp.size() == 0 || qa_acc.size() == 0) check("a_unexpected_beat", 1, 0);
        else begin
          e = qa_exp.pop_front();
          check("a_rd_data", ifa.app_rd_data, e);
          check("a_rd_latency", cyc - qa_acc.pop_front(), LAT);
          check("a_rd_end", ifa.app_rd_data_end, 1);
        end
      end
      if (ifb.app_rd_data_valid) begin
        beats_b++;
        if (qb_exp.size() == 0 || qb_acc.size() == 0) check("b_unexpected_beat", 1, 0);
        else begin
          e = qb_exp.pop_front();
          check("b_rd_data", ifb.app_rd_data, e);
          check("b_rd_latency", cyc - qb_acc.pop_front(), LAT);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok;
    idle(0); idle(1);
    sys_rst = 1'b1;
    @(negedge ui_clk) sys_rst = 1'b0;
    repeat (3) @(negedge ui_clk);
    check("rst_calib", calib_a, 0);
    check("rst_err", err_a, 0);
    check("rst_counts", {wc_a, rc_a}, 0);
    check("rst_rdy", {ifa.app_rdy, ifa.app_wdf_rdy}, 0);
    check("rst_rd_data", ifa.app_rd_data, 0);
    check("rst_valid", {ifa.app_rd_data_valid, ifa.app_rd_data_end}, 0);

    // Calibration window: edges counted from reset release.
    sys_rst = 1'b1;
    repeat (500) @(negedge ui_clk);
    check("cal_rdy_low", {ifa.app_rdy, ifa.app_wdf_rdy}, 0);
    put(1, 1'b1, 3'd1, '0, 1'b0, 1'b0, '0, '0);
    @(negedge ui_clk);
    idle(1);
    check("b_early_en_err", err_b, 1);
    check("b_early_en_no_read", rc_b, 0);
    repeat (498) @(negedge ui_clk);
    check("cal_999_low", {calib_a, ifa.app_rdy}, 0);
    @(negedge ui_clk);
    check("cal_1000_high", calib_a, 1);
    check("cal_rdy_up", {ifa.app_rdy, ifa.app_wdf_rdy}, 2'b11);
    check("cal_b_high", calib_b, 1);

    // Write/readback across 198 words.
    for (int i = 0; i < 198; i++) do_write(0, AW'(i * 8), DW'(i + 1), '0);
    for (int i = 0; i < 198; i++) do_read(0, AW'(i * 8), DW'(i + 1));
    drain();
    check("wb_wr_count", wc_a, 198);
    check("wb_rd_count", rc_a, 198);
    check("wb_no_err", err_a, 0);

    // Byte mask and address wrap.
    do_write(0, '0, '1, '0);
    do_write(0, '0, '0, 32'hFFFF_FFFE);
    do_read(0, '0, {{31{8'hFF}}, 8'h00});
    drain();
    do_write(0, '0, DW'(8'hAA), '0);
    do_write(0, AW'(2048), DW'(8'h55), '0);
    do_read(0, '0, DW'(8'h55));
    drain();
    check("wrap_wr_count", wc_a, 202);
    check("wrap_rd_count", rc_a, 200);

    // Sustained reads against a 4-cycle stall pattern.
    for (int i = 0; i < 15; i++) do_write(1, AW'(i * 8), DW'(100 + i), '0);
    beats_b = 0;
    read_hold(1, 20, 99, 0, 100, n);
    drain();
    check("b_burst_accepted", n, 15);
    check("b_burst_rd_count", rc_b, 15);
    check("b_burst_beats", beats_b, 15);

    // Write in phase 0, read of the same word in phase 1.
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!ifb.app_rdy) begin ok = 1'b1; break; end
      @(negedge ui_clk);
    end
    check("b_stall_seen", ok, 1);
    @(negedge ui_clk);
    check("b_phase0_rdy", {ifb.app_rdy, ifb.app_wdf_rdy}, 2'b11);
    put(1, 1'b1, 3'd0, AW'(320), 1'b1, 1'b1, DW'(32'hC0FFEE), '0);
    @(negedge ui_clk);
    check("b_phase1_rdy", {ifb.app_rdy, ifb.app_wdf_rdy}, 2'b10);
    push_exp(1, DW'(32'hC0FFEE));
    put(1, 1'b1, 3'd1, AW'(320), 1'b0, 1'b0, '0, '0);
    @(negedge ui_clk);
    idle(1);
    drain();

    // Protocol violations are flagged and ignored.
    wait_ready(0, 1'b0, ok);
    put(0, 1'b1, 3'd3, '0, 1'b0, 1'b0, '0, '0);
    @(negedge ui_clk);
    idle(0);
    check("bad_cmd_err", err_a, 1);
    check("bad_cmd_counts", {wc_a, rc_a}, {16'd202, 16'd200});
    wait_ready(0, 1'b0, ok);
    put(0, 1'b1, 3'd0, AW'(8), 1'b0, 1'b0, DW'(77), '0);
    @(negedge ui_clk);
    idle(0);
    check("wr_no_wren_err", err_a, 1);
    check("wr_no_wren_count", wc_a, 202);

    // Reset with five reads in flight.
    read_hold(0, 20, 5, 1, 2, n);
    check("inflight_issued", n, 5);
    @(negedge ui_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge ui_clk);
    check("midrst_valid", ifa.app_rd_data_valid, 0);
    check("midrst_state", {calib_a, err_a, wc_a, rc_a}, 0);
    sys_rst = 1'b1;
    for (int i = 0; i < 1100 && !calib_a; i++) @(negedge ui_clk);
    check("recal_done", calib_a, 1);
    do_read(0, AW'(8), DW'(2));
    do_read(0, AW'(16), DW'(3));
    do_read(0, AW'(800), DW'(101));
    do_read(0, '0, DW'(8'h55));
    drain();
    check("recal_rd_count", rc_a, 4);
    check("recal_no_err", err_a, 0);

    wait_ready(0, 1'b1, ok);
    put(0, 1'b0, 3'd0, '0, 1'b1, 1'b0, DW'(9), '0);
    @(negedge ui_clk);
    idle(0);
    check("wren_no_end_err", err_a, 1);
    check("wren_no_end_count", wc_a, 0);

    repeat (12) @(negedge ui_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
